// File: rtl/neuron_lut_arbiter_pkg.sv
// Shared sizing defaults for the neuron LUT arbiter and its round-robin grant logic.
package neuron_lut_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int IN_W_DEF    = 8;
    localparam int OUT_W_DEF   = 2;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    // Keeps the index at least one bit wide even for a degenerate requester count.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_lut_arbiter_rr_grant.sv
// Round-robin grant: first valid requester at or above ptr, wrapping modulo N.
module rr_grant
    import neuron_lut_arbiter_pkg::*;
#(
    parameter int N    = NUM_REQ_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/neuron_lut_arbiter.sv
// Shares one external combinational neuron LUT between NUM_REQ requesters with a
// round-robin grant and a single registered, back-pressured result stage.
module neuron_lut_arbiter
    import neuron_lut_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         lut_in,
    input  logic [OUT_W-1:0]        lut_out,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id,
    input  logic                    out_ready
);

    logic              advance;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W-1:0]    ptr;

    assign advance = !out_valid || out_ready;
    // Masking with rst_n keeps req_ready low while reset is held.
    assign cand    = (advance && rst_n) ? req_valid : '0;

    rr_grant #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_grant (
        .valid (cand),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready = grant;

    always_comb begin
        lut_in = '0;
        if (grant_any) begin
            lut_in = req_data[int'(grant_idx)*IN_W +: IN_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (grant_any) begin
            out_valid <= 1'b1;
            out_data  <= lut_out;
            out_id    <= grant_idx;
            ptr       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (advance) begin
            out_valid <= 1'b0;
        end
    end

endmodule
